// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the control unit and alu_seq.
//   master : control unit; drives start, data1, data2, select.
//   slave  : alu_seq; returns result, zero, busy, done
//            (plus carry, overflow when ALU_SEQ_FLAGS_EN is defined).
// Optional macro: ALU_SEQ_FLAGS_EN adds the carry/overflow flag signals.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [2:0]       select;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
`ifdef ALU_SEQ_FLAGS_EN
    logic             carry;
    logic             overflow;

    modport master (output start, data1, data2, select,
                    input  result, zero, busy, done, carry, overflow);
    modport slave  (input  start, data1, data2, select,
                    output result, zero, busy, done, carry, overflow);
`else
    modport master (output start, data1, data2, select,
                    input  result, zero, busy, done);
    modport slave  (input  start, data1, data2, select,
                    output result, zero, busy, done);
`endif
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a start/busy/done handshake.
//   Opcodes: 000 FORWARD(data2), 001 ADD, 010 AND, 011 OR,
//            100 MULT (shift-add, 1 bit/cycle), 101 SLL, 110 SRL, 111 SRA
//            (1 bit/cycle, amount saturated at WIDTH).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : alu_seq_if.slave (start/data1/data2/select in,
//           result/zero/busy/done out, registered)
// Optional macro: ALU_SEQ_FLAGS_EN adds registered carry/overflow outputs and
// widens the MULT accumulator to 2*WIDTH so the high half can be checked.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);

`ifdef ALU_SEQ_FLAGS_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  W_CNT = CNTW'(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;

    state_t           state, state_nx;
    logic [2:0]       op;
    logic [AW-1:0]    acc;      // working register / product accumulator
    logic [AW-1:0]    mcand;    // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier;   // multiplier, shifted right each step
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, busy_q, done_q;
    logic             accept;
    logic [CNTW-1:0]  sh_cnt;
    logic [WIDTH-1:0] simple, sh_res, lo;
    logic [AW-1:0]    mult_step;

`ifdef ALU_SEQ_FLAGS_EN
    logic [WIDTH:0]   sum;
    logic             add_ovf, sh_out;
    logic             cf, vf;           // flags tracked while the op runs
    logic             carry_q, overflow_q;
    assign sum     = {1'b0, bus.data1} + {1'b0, bus.data2};
    assign add_ovf = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.data1[WIDTH-1]);
`else
    logic [WIDTH-1:0] sum;
    assign sum = bus.data1 + bus.data2;
`endif

    // busy also covers the done cycle, so a start there is ignored
    assign accept = (state == IDLE) && bus.start && !busy_q;
    assign sh_cnt = (bus.data2 >= W_VAL) ? W_CNT : CNTW'(bus.data2);
    assign lo     = acc[WIDTH-1:0];

    always_comb begin
        case (bus.select[1:0])
            2'b00:   simple = bus.data2;
            2'b01:   simple = sum[WIDTH-1:0];
            2'b10:   simple = bus.data1 & bus.data2;
            default: simple = bus.data1 | bus.data2;
        endcase
    end

    always_comb begin
        sh_res = lo;
`ifdef ALU_SEQ_FLAGS_EN
        sh_out = 1'b0;
`endif
        case (op)
            3'b101: begin
                sh_res = {lo[WIDTH-2:0], 1'b0};
`ifdef ALU_SEQ_FLAGS_EN
                sh_out = lo[WIDTH-1];
`endif
            end
            3'b110: begin
                sh_res = {1'b0, lo[WIDTH-1:1]};
`ifdef ALU_SEQ_FLAGS_EN
                sh_out = lo[0];
`endif
            end
            3'b111: begin
                sh_res = {lo[WIDTH-1], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_FLAGS_EN
                sh_out = lo[0];
`endif
            end
            default: ;
        endcase
    end

    assign mult_step = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!bus.select[2])          state_nx = FIN;
                    else if (bus.select == 3'b100) state_nx = EXEC;
                    else if (sh_cnt == '0)       state_nx = FIN;
                    else                         state_nx = EXEC;
                end
            end
            EXEC:    if (cnt == CNTW'(1)) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op       <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            cf         <= 1'b0;
            vf         <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_nx != IDLE) || (state == FIN);
            case (state)
                IDLE: if (accept) begin
                    op <= bus.select;
`ifdef ALU_SEQ_FLAGS_EN
                    cf <= 1'b0;
                    vf <= 1'b0;
`endif
                    if (!bus.select[2]) begin
                        acc <= AW'(simple);
                        cnt <= '0;
`ifdef ALU_SEQ_FLAGS_EN
                        if (bus.select == 3'b001) begin
                            cf <= sum[WIDTH];
                            vf <= add_ovf;
                        end
`endif
                    end else if (bus.select == 3'b100) begin
                        acc    <= '0;
                        mcand  <= AW'(bus.data1);
                        mplier <= bus.data2;
                        cnt    <= W_CNT;
                    end else begin
                        acc <= AW'(bus.data1);
                        cnt <= sh_cnt;
                    end
                end
                EXEC: begin
                    cnt <= cnt - CNTW'(1);
                    if (op == 3'b100) begin
                        acc    <= mult_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        acc <= AW'(sh_res);
`ifdef ALU_SEQ_FLAGS_EN
                        cf  <= sh_out;
`endif
                    end
                end
                FIN: begin
                    result_q <= lo;
                    zero_q   <= (lo == '0);
                    done_q   <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                    carry_q    <= (op == 3'b100) ? (|acc[AW-1:WIDTH]) : cf;
                    overflow_q <= vf;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign bus.carry    = carry_q;
    assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven vectors plus hand-written multi-cycle sequences for
// alu_seq (WIDTH=8). Expected results are queued when start is driven and
// checked (result, zero, latency, optional flags) when done pulses.
module tb_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] d1, d2;
        logic [W-1:0] res;
        logic         z, c, v;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z, c, v;
        int           lat;
        int           start_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[17];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // scoreboard side: compare on each done pulse
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done pulse with nothing outstanding at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("result",  32'(bus.result), 32'(e.res));
                chk("zero",    32'(bus.zero),   32'(e.z));
                chk("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
`ifdef ALU_SEQ_FLAGS_EN
                chk("carry",    32'(bus.carry),    32'(e.c));
                chk("overflow", 32'(bus.overflow), 32'(e.v));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL idle_timeout: busy stuck high");
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: %0d results never arrived", sb.size());
            sb.delete();
        end
        tick();
    endtask

    // drive one start pulse; optionally queue its expected outcome
    task automatic issue(input vec_t v, input bit push);
        exp_t e;
        bus.start  = 1'b1;
        bus.select = v.sel;
        bus.data1  = v.d1;
        bus.data2  = v.d2;
        if (push) begin
            e.res = v.res; e.z = v.z; e.c = v.c; e.v = v.v;
            e.lat = v.lat; e.start_cyc = cyc + 1;
            sb.push_back(e);
        end
        tick();
        bus.start = 1'b0;
    endtask

    function automatic vec_t mk(logic [2:0] sel, logic [W-1:0] d1, logic [W-1:0] d2,
                                logic [W-1:0] res, logic z, logic c, logic v, int lat);
        vec_t r;
        r.sel = sel; r.d1 = d1; r.d2 = d2; r.res = res;
        r.z = z; r.c = c; r.v = v; r.lat = lat;
        return r;
    endfunction

    initial begin
        int d0;
        //             sel     d1     d2     res    z  c  v  lat
        vecs[0]  = mk(3'b001, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 2);
        vecs[1]  = mk(3'b100, 8'd13, 8'd11, 8'h8F, 0, 0, 0, 10);
        vecs[2]  = mk(3'b100, 8'h10, 8'h10, 8'h00, 1, 1, 0, 10);
        vecs[3]  = mk(3'b111, 8'h90, 8'd3,  8'hF2, 0, 0, 0, 5);
        vecs[4]  = mk(3'b110, 8'hB5, 8'd200,8'h00, 1, 1, 0, 10);
        vecs[5]  = mk(3'b101, 8'h3C, 8'd0,  8'h3C, 0, 0, 0, 2);
        vecs[6]  = mk(3'b000, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 2);
        vecs[7]  = mk(3'b010, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 2);
        vecs[8]  = mk(3'b011, 8'hF0, 8'h0C, 8'hFC, 0, 0, 0, 2);
        vecs[9]  = mk(3'b001, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 2);
        vecs[10] = mk(3'b101, 8'h81, 8'd1,  8'h02, 0, 1, 0, 3);
        vecs[11] = mk(3'b111, 8'h80, 8'd8,  8'hFF, 0, 1, 0, 10);
        vecs[12] = mk(3'b111, 8'h80, 8'd255,8'hFF, 0, 1, 0, 10);
        vecs[13] = mk(3'b101, 8'h01, 8'd7,  8'h80, 0, 0, 0, 9);
        vecs[14] = mk(3'b100, 8'hFF, 8'hFF, 8'h01, 0, 1, 0, 10);
        vecs[15] = mk(3'b001, 8'h80, 8'h80, 8'h00, 1, 1, 1, 2);
        vecs[16] = mk(3'b110, 8'h81, 8'd1,  8'h40, 0, 1, 0, 3);

        bus.start = 1'b0; bus.select = '0; bus.data1 = '0; bus.data2 = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_result", 32'(bus.result), 32'h0);
        chk("rst_zero",   32'(bus.zero),   32'h1);
        chk("rst_busy",   32'(bus.busy),   32'h0);
        chk("rst_done",   32'(bus.done),   32'h0);
        tick();

        foreach (vecs[i]) begin
            wait_idle();
            issue(vecs[i], 1'b1);
            chk("busy_after_start", 32'(bus.busy), 32'h1);
            wait_drain();
            chk("busy_after_done", 32'(bus.busy), 32'h0);
        end

        // start while busy: second request must be dropped
        wait_idle();
        d0 = done_cnt;
        issue(mk(3'b100, 8'd13, 8'd11, 8'h8F, 0, 0, 0, 10), 1'b1);
        tick();
        issue(mk(3'b001, 8'h01, 8'h01, 8'h02, 0, 0, 0, 2), 1'b0);
        wait_drain();
        repeat (5) tick();
        chk("single_done", 32'(done_cnt - d0), 32'd1);

        // operands wiggle after start; latched copies must be used
        wait_idle();
        bus.start = 1'b1; bus.select = 3'b100; bus.data1 = 8'd7; bus.data2 = 8'd6;
        begin
            exp_t e;
            e.res = 8'd42; e.z = 0; e.c = 0; e.v = 0; e.lat = 10; e.start_cyc = cyc + 1;
            sb.push_back(e);
        end
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bus.data1 = W'($urandom);
            bus.data2 = W'($urandom);
            tick();
        end
        wait_drain();

        // reset in the middle of a MULT: aborted, no done
        wait_idle();
        d0 = done_cnt;
        issue(mk(3'b100, 8'd9, 8'd9, 8'd81, 0, 0, 0, 10), 1'b0);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy",   32'(bus.busy),   32'h0);
        chk("midrst_result", 32'(bus.result), 32'h0);
        chk("midrst_zero",   32'(bus.zero),   32'h1);
        chk("midrst_done",   32'(bus.done),   32'h0);
        repeat (12) tick();
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        wait_idle();
        issue(mk(3'b000, 8'h00, 8'hA5, 8'hA5, 0, 0, 0, 2), 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
